fpu_add_arbiter: RTL and testbench
==================================

// Module: fpu_add_arbiter
// PURPOSE
// - Shares one Adder_cntrl floating-point add unit between NUM_REQ requesters.
// - Arbitration is round-robin. One operation is in flight at a time.
// - Latches the winner's operands and drives the adder caller interface.
// - Returns the result to the requesters, tagged with the requester id.
// - Sits between the FPU issue logic / client ports and Adder_cntrl.
// PARAMETERS
// - NUM_REQ      4    number of requesters, 2..8; ID_W = $clog2(NUM_REQ)
// - TIMEOUT_CYC  64   watchdog limit in cycles, WAIT state; used only with FPU_ARB_TIMEOUT_EN
// PORTS
// - CLK                in   1            clock
// - RSTn               in   1            synchronous, active-low reset
// - req_valid          in   NUM_REQ      per-requester request; held high with operands until req_ack
// - req_op1            in   NUM_REQ*32   operand 1, IEEE-754 single; requester i at [32*i +: 32]
// - req_op2            in   NUM_REQ*32   operand 2, same packing
// - req_mode           in   NUM_REQ*3    mode field; requester i at [3*i +: 3]
// - req_ack            out  NUM_REQ      one-hot, 1-cycle pulse: request accepted
// - rsp_valid          out  1            1-cycle pulse: result available
// - rsp_id             out  ID_W         requester index owning the result
// - rsp_data           out  32           sum
// - rsp_exc            out  3            exception code from adder; 3'b111 = watchdog timeout
// - busy               out  1            high in every state except IDLE
// - add_datain1        out  32           to Adder_cntrl Datain1
// - add_datain2        out  32           to Adder_cntrl Datain2
// - add_mode           out  3            to Adder_cntrl Mode
// - add_data_valid     out  1            to Adder_cntrl Data_valid; 1-cycle pulse
// - add_dataout        in   32           from Adder_cntrl Dataout
// - add_dataout_valid  in   1            from Adder_cntrl Dataout_valid; 1-cycle pulse
// - add_exc            in   3            from Adder_cntrl Exc
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: outputs 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
// - A reset mid-operation abandons the op: no rsp_valid, no req_ack.
// - States:
//   - IDLE: if |req_valid, winner = first set bit scanning upward from last_grant+1 (mod NUM_REQ).
//     Latch op1/op2/mode and id; last_grant <= winner; -> ISSUE. Otherwise stay in IDLE.
//   - ISSUE (1 cycle): add_data_valid = 1; add_datain1/2/mode = latched values; req_ack[id] = 1; -> WAIT.
//   - WAIT: add_datain* hold the latched values, add_data_valid = 0.
//     On add_dataout_valid: capture add_dataout -> rsp_data and add_exc -> rsp_exc; -> RESP.
//   - RESP (1 cycle): rsp_valid = 1, rsp_id = id; -> IDLE.
// - Throughput: 1 op per (adder latency + 3) cycles.
// - Latency: req_valid high in IDLE at cycle t -> req_ack/add_data_valid at t+1.
//   Adder Dataout_valid at cycle u -> rsp_valid at u+1.
// - add_dataout_valid outside WAIT is ignored, including a pulse coincident with ISSUE.
// - rsp_data/rsp_exc/rsp_id hold their last values after RESP; only rsp_valid returns to 0.
// - A requester that drops req_valid before ack is simply not granted.
// - Changes to the winner's inputs after the IDLE grant cycle do not affect the in-flight op.
// - New requests arriving while busy wait. Round-robin guarantees each active requester is
//   served within NUM_REQ grants.
// - The requester just served may re-assert in RESP. It is granted next only if no other
//   requester is pending.
// CONFIGURATION
// - `define FPU_ARB_TIMEOUT_EN:
//   - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
//   - If it reaches TIMEOUT_CYC without add_dataout_valid: -> RESP with rsp_data = 0, rsp_exc = 3'b111.
//   - A late add_dataout_valid after the timeout is ignored per the rule above.
// - Without the macro: no counter; WAIT persists until add_dataout_valid.
// TESTING
// 1. Single request: req_valid=4'b0001, op1=32'h3F800000, op2=32'h40000000; adder model returns
//    32'h40400000 after 5 cycles.
//    -> req_ack=0001 at t+1; rsp_valid with rsp_id=0, rsp_data=32'h40400000, rsp_exc=0.
// 2. Contention: req_valid=4'b1111 held, each re-asserted after its ack.
//    -> grant order 0,1,2,3,0; exactly one req_ack bit per op.
// 3. Fairness: req 2 asserted continuously, req 1 asserted once after reset.
//    -> grants 1 then 2; after that, 2 on every op.
// 4. Exception pass-through: adder returns Exc=3'b010 for requester 3.
//    -> rsp_id=3, rsp_exc=3'b010.
// 5. Reset mid-op: RSTn=0 during WAIT.
//    -> next cycle busy=0, no rsp_valid; first post-reset grant goes to requester 0 when all request.
// 6. FPU_ARB_TIMEOUT_EN with TIMEOUT_CYC=8, adder never responds.
//    -> rsp_valid 8 cycles after entering WAIT, rsp_exc=3'b111, rsp_data=0.
//    A late adder pulse produces no second rsp_valid.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin arbiter sharing one Adder_cntrl floating-point
// add unit between NUM_REQ requesters, one operation in flight at a time.
// The winner's operands are latched into the adder interface registers, and
// the result is returned to the requesters tagged with the requester id.
// Optional feature macro: FPU_ARB_TIMEOUT_EN enables a WAIT-state watchdog of
// TIMEOUT_CYC cycles that completes the op with rsp_exc = 3'b111, rsp_data = 0.
// All outputs are registered; reset is synchronous, active-low.
module fpu_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_op1,
    input  logic [NUM_REQ*32-1:0] req_op2,
    input  logic [NUM_REQ*3-1:0]  req_mode,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [2:0]            rsp_exc,
    output logic                  busy,
    output logic [31:0]           add_datain1,
    output logic [31:0]           add_datain2,
    output logic [2:0]            add_mode,
    output logic                  add_data_valid,
    input  logic [31:0]           add_dataout,
    input  logic                  add_dataout_valid,
    input  logic [2:0]            add_exc
);

    localparam int unsigned NREQ = NUM_REQ;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("fpu_add_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // last_grant doubles as the id of the op in flight once a grant is made
    logic [ID_W-1:0]    last_grant, last_grant_nxt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic               dv_nxt;
    logic               rv_nxt;
    logic               busy_nxt;
    logic [31:0]        d1_nxt, d2_nxt;
    logic [2:0]         mode_nxt;
    logic [ID_W-1:0]    rsp_id_nxt;
    logic [31:0]        rsp_data_nxt;
    logic [2:0]         rsp_exc_nxt;

    logic               win_found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    cand;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // Last WAIT cycle before the watchdog fires
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counter: cleared on entry to WAIT, counts WAIT cycles
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // Round-robin scan starting one past the last grant, plus next-state and
    // next-output computation; outputs are registered from these values
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        ack_nxt        = '0;
        dv_nxt         = 1'b0;
        rv_nxt         = 1'b0;
        d1_nxt         = add_datain1;
        d2_nxt         = add_datain2;
        mode_nxt       = add_mode;
        rsp_id_nxt     = rsp_id;
        rsp_data_nxt   = rsp_data;
        rsp_exc_nxt    = rsp_exc;
        win_found      = 1'b0;
        win            = '0;
        cand           = '0;

        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end

        unique case (state)
            S_IDLE: begin
                if (win_found) begin
                    last_grant_nxt = win;
                    ack_nxt[win]   = 1'b1;
                    dv_nxt         = 1'b1;
                    d1_nxt         = req_op1[32*win +: 32];
                    d2_nxt         = req_op2[32*win +: 32];
                    mode_nxt       = req_mode[3*win +: 3];
                    state_nxt      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (add_dataout_valid) begin
                    rv_nxt       = 1'b1;
                    rsp_id_nxt   = last_grant;
                    rsp_data_nxt = add_dataout;
                    rsp_exc_nxt  = add_exc;
                    state_nxt    = S_RESP;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    rv_nxt       = 1'b1;
                    rsp_id_nxt   = last_grant;
                    rsp_data_nxt = '0;
                    rsp_exc_nxt  = 3'b111;
                    state_nxt    = S_RESP;
                end
`endif
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State, arbitration pointer and all output registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state          <= S_IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            req_ack        <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_data       <= '0;
            rsp_exc        <= '0;
            busy           <= 1'b0;
            add_datain1    <= '0;
            add_datain2    <= '0;
            add_mode       <= '0;
            add_data_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            last_grant     <= last_grant_nxt;
            req_ack        <= ack_nxt;
            rsp_valid      <= rv_nxt;
            rsp_id         <= rsp_id_nxt;
            rsp_data       <= rsp_data_nxt;
            rsp_exc        <= rsp_exc_nxt;
            busy           <= busy_nxt;
            add_datain1    <= d1_nxt;
            add_datain2    <= d2_nxt;
            add_mode       <= mode_nxt;
            add_data_valid <= dv_nxt;
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Self-checking bench for fpu_add_arbiter: directed requester scenarios, a
// behavioural adder stub, a transaction-level model compared every cycle,
// and literal expectations for grant order, latency and response fields.
`timescale 1ns/1ps
module tb_fpu_add_arbiter;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int TB_TO = 8;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*32-1:0]  req_op1 = '0;
    logic [N*32-1:0]  req_op2 = '0;
    logic [N*3-1:0]   req_mode = '0;
    logic [N-1:0]     req_ack;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [31:0]      rsp_data;
    logic [2:0]       rsp_exc;
    logic             busy;
    logic [31:0]      add_datain1, add_datain2;
    logic [2:0]       add_mode;
    logic             add_data_valid;
    logic [31:0]      add_dataout = '0;
    logic             add_dataout_valid = 1'b0;
    logic [2:0]       add_exc = '0;

    always #5 CLK = ~CLK;

    fpu_add_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TB_TO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_exc(rsp_exc), .busy(busy),
        .add_datain1(add_datain1), .add_datain2(add_datain2), .add_mode(add_mode),
        .add_data_valid(add_data_valid), .add_dataout(add_dataout),
        .add_dataout_valid(add_dataout_valid), .add_exc(add_exc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- adder stub: responds adder_lat cycles after Data_valid
    int          adder_lat = 3;
    bit          force_res = 1'b0;
    logic [31:0] force_val = '0;
    logic [2:0]  stub_exc  = '0;
    int          stub_cnt  = -1;
    logic [31:0] stub_res  = '0;
    bit          stub_fire;

    always @(posedge CLK) begin
        stub_fire = 1'b0;
        if (!RSTn) begin
            stub_cnt = -1;
        end else if (add_data_valid === 1'b1) begin
            stub_cnt = adder_lat - 1;
            stub_res = force_res ? force_val : add_datain1 + add_datain2;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) stub_fire = 1'b1;
        end
        #1;
        add_dataout_valid = stub_fire;
        if (stub_fire) begin
            add_dataout = stub_res;
            add_exc     = stub_exc;
        end
    end

    // ---------------- requesters: hold request until acked req_cnt times
    int          req_cnt [N];
    logic [31:0] op1_v [N];
    logic [31:0] op2_v [N];
    logic [2:0]  mode_v [N];
    int          grants [$];

    always @(posedge CLK) begin
        #1;
        if (req_ack !== '0) begin
            check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
            for (int i = 0; i < N; i++) if (req_ack[i]) grants.push_back(i);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ack[i] === 1'b1 && req_cnt[i] > 0) begin
                req_cnt[i]--;
                op1_v[i] = op1_v[i] + 32'h0001_0000;
                op2_v[i] = op2_v[i] ^ 32'h0000_0F00;
                mode_v[i] = mode_v[i] + 3'd1;
            end
            req_valid[i]         = (req_cnt[i] > 0);
            req_op1[32*i +: 32]  = op1_v[i];
            req_op2[32*i +: 32]  = op2_v[i];
            req_mode[3*i +: 3]   = mode_v[i];
        end
    end

    // ---------------- transaction-level model
    // An op occupies: grant edge (ack + issue visible for one cycle), then the
    // adder wait (results only accepted from the second cycle after grant),
    // one response cycle, then the unit is free again.
    bit              m_ready = 1'b0;
    bit              m_active = 1'b0;
    bit              m_done = 1'b0;
    int              m_age = 0;
    int              m_last = N - 1;
    logic [N-1:0]    e_ack = '0;
    logic            e_dv = 1'b0, e_rv = 1'b0, e_busy = 1'b0;
    logic [31:0]     e_d1 = '0, e_d2 = '0, e_rd = '0;
    logic [2:0]      e_mode = '0, e_exc = '0;
    logic [IDW-1:0]  e_id = '0;

    always @(posedge CLK) begin
        e_ack = '0;
        e_dv  = 1'b0;
        e_rv  = 1'b0;
        if (!RSTn) begin
            m_ready = 1'b1; m_active = 1'b0; m_done = 1'b0; m_last = N - 1;
            e_d1 = '0; e_d2 = '0; e_mode = '0; e_rd = '0; e_exc = '0; e_id = '0;
        end else if (!m_active) begin
            if (req_valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_last + k) % N]) begin
                        m_last = (m_last + k) % N;
                        break;
                    end
                end
                m_active = 1'b1; m_done = 1'b0; m_age = 0;
                e_ack[m_last] = 1'b1;
                e_dv   = 1'b1;
                e_d1   = req_op1[32*m_last +: 32];
                e_d2   = req_op2[32*m_last +: 32];
                e_mode = req_mode[3*m_last +: 3];
            end
        end else if (m_done) begin
            m_active = 1'b0;
        end else begin
            m_age++;
            if (m_age >= 2 && add_dataout_valid) begin
                e_rv = 1'b1; e_rd = add_dataout; e_exc = add_exc; e_id = IDW'(m_last);
                m_done = 1'b1;
            end
`ifdef FPU_ARB_TIMEOUT_EN
            else if (m_age == TB_TO + 1) begin
                e_rv = 1'b1; e_rd = '0; e_exc = 3'b111; e_id = IDW'(m_last);
                m_done = 1'b1;
            end
`endif
        end
        e_busy = m_active;
    end

    // Compare every output against the model away from the active edge
    always @(negedge CLK) begin
        if (m_ready) begin
            check("req_ack", 32'(req_ack), 32'(e_ack));
            check("add_data_valid", 32'(add_data_valid), 32'(e_dv));
            check("add_datain1", add_datain1, e_d1);
            check("add_datain2", add_datain2, e_d2);
            check("add_mode", 32'(add_mode), 32'(e_mode));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("rsp_id", 32'(rsp_id), 32'(e_id));
            check("rsp_data", rsp_data, e_rd);
            check("rsp_exc", 32'(rsp_exc), 32'(e_exc));
            check("busy", 32'(busy), 32'(e_busy));
        end
    end

    // ---------------- helpers
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        for (int i = 0; i < N; i++) req_cnt[i] = 0;
        @(posedge CLK); #1;
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    task automatic wait_ack();
        bit ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (req_ack != '0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL ack_wait: no req_ack within 60 cycles");
        end
    endtask

    task automatic wait_rsp(output int n);
        bit ok = 1'b0;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            n++;
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL rsp_wait: no rsp_valid within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        int pend;
        for (int c = 0; c < 500; c++) begin
            tick();
            pend = 0;
            for (int i = 0; i < N; i++) pend += req_cnt[i];
            if (pend == 0 && busy === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_assert++; n_fail++;
            $display("FAIL idle_wait: arbiter did not drain within 500 cycles");
        end
    endtask

    task automatic check_grants(input string name, input int exp_q [$]);
        check({name, "_count"}, 32'(grants.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grants.size(); i++)
            check(name, 32'(grants[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int n;
        int rv_seen;
        int exp2 [$];
        int exp3 [$];

        for (int i = 0; i < N; i++) begin
            req_cnt[i] = 0;
            op1_v[i]  = 32'h4100_0000 + 32'(i);
            op2_v[i]  = 32'h3F00_0000 + 32'(i << 8);
            mode_v[i] = 3'(i + 1);
        end
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{1, 2, 2, 2, 2};

        // reset state
        do_reset();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_datain1", add_datain1, 32'd0);

        // 1: single request, adder latency 5
        @(negedge CLK);
        force_res = 1'b1; force_val = 32'h4040_0000; adder_lat = 5;
        op1_v[0] = 32'h3F80_0000; op2_v[0] = 32'h4000_0000; mode_v[0] = 3'd0;
        req_cnt[0] = 1;
        wait_ack();
        check("t1_ack", 32'(req_ack), 32'h1);
        check("t1_datain1", add_datain1, 32'h3F80_0000);
        check("t1_datain2", add_datain2, 32'h4000_0000);
        wait_rsp(n);
        check("t1_ack_to_rsp", 32'(n), 32'd6);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_data", rsp_data, 32'h4040_0000);
        check("t1_rsp_exc", 32'(rsp_exc), 32'd0);
        wait_idle();
        force_res = 1'b0; adder_lat = 3;

        // 2: contention, all four requesting, requester 0 twice
        do_reset();
        grants.delete();
        @(negedge CLK);
        req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
        wait_idle();
        check_grants("t2_grant", exp2);

        // 3: fairness, 2 continuous, 1 once
        do_reset();
        grants.delete();
        @(negedge CLK);
        req_cnt[2] = 4; req_cnt[1] = 1;
        wait_idle();
        check_grants("t3_grant", exp3);

        // 4: exception pass-through for requester 3, fields held after RESP
        @(negedge CLK);
        stub_exc = 3'b010;
        req_cnt[3] = 1;
        wait_rsp(n);
        check("t4_rsp_id", 32'(rsp_id), 32'd3);
        check("t4_rsp_exc", 32'(rsp_exc), 32'b010);
        tick();
        check("t4_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("t4_rsp_id_hold", 32'(rsp_id), 32'd3);
        check("t4_rsp_exc_hold", 32'(rsp_exc), 32'b010);
        wait_idle();
        stub_exc = 3'b000;

        // 5: reset during WAIT abandons the op
        do_reset();
        @(negedge CLK);
        adder_lat = 10;
        req_cnt[0] = 1;
        wait_ack();
        tick(); tick();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        check("t5_busy_after_reset", 32'(busy), 32'd0);
        check("t5_rsp_after_reset", 32'(rsp_valid), 32'd0);
        rv_seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (rsp_valid === 1'b1) rv_seen++;
        end
        check("t5_no_rsp", 32'(rv_seen), 32'd0);
        adder_lat = 3;
        grants.delete();
        @(negedge CLK);
        for (int i = 0; i < N; i++) req_cnt[i] = 1;
        wait_ack();
        check("t5_first_grant", 32'(req_ack), 32'h1);
        wait_idle();

`ifdef FPU_ARB_TIMEOUT_EN
        // 6: watchdog, adder answers far too late
        do_reset();
        @(negedge CLK);
        adder_lat = 20;
        req_cnt[0] = 1;
        wait_ack();
        wait_rsp(n);
        check("t6_ack_to_rsp", 32'(n), 32'd9);
        check("t6_rsp_exc", 32'(rsp_exc), 32'b111);
        check("t6_rsp_data", rsp_data, 32'd0);
        rv_seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rsp_valid === 1'b1) rv_seen++;
        end
        check("t6_no_late_rsp", 32'(rv_seen), 32'd0);
        adder_lat = 3;
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
